// File: rtl/nes_joypad_pkg.sv
// Shared definitions for the NES joypad controller:
// button bit order, HPS register map and arbitration modes.
package nes_joypad_pkg;

   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   localparam logic [1:0] REG_HPS_PAD   = 2'd0;
   localparam logic [1:0] REG_CTRL      = 2'd1;
   localparam logic [1:0] REG_PAD_STATE = 2'd2;
   localparam logic [1:0] REG_SHIFT_CNT = 2'd3;

   localparam logic [3:0] SHIFT_SAT = 4'd8;

   typedef enum logic [1:0] {
      MODE_BOARD     = 2'b00,
      MODE_HPS       = 2'b01,
      MODE_MERGE     = 2'b10,
      MODE_MERGE_ALT = 2'b11
   } mode_e;

   function automatic logic [7:0] merge_pad(
      input mode_e      mode,
      input logic [7:0] board,
      input logic [7:0] hps
   );
      logic [7:0] w;
      case (mode)
         MODE_BOARD: w = board;
         MODE_HPS:   w = hps;
         default:    w = board | hps;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/joypad_debounce.sv
// One-bit synchronizer followed by a stability counter;
// the output follows the input only after it has held long enough.
module joypad_debounce
   import nes_joypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   state_q, state_d;
   logic                   in_s;

   assign in_s = sync_q[SYNC_STAGES-1];
   assign dout = state_q;

   always_comb begin
      sync_d[0] = din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   always_comb begin
      cnt_d   = cnt_q;
      state_d = state_q;
      if (in_s == state_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         state_d = in_s;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         state_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

endmodule

// File: rtl/nes_joypad_ctrl.sv
// NES $4016 joypad built from board keys/switches and an HPS-written
// button word, with a small Avalon register slave for software.
module nes_joypad_ctrl
   import nes_joypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic       clk_clk,
   input  logic       reset_reset_n,
   input  logic [3:0] board_key,
   input  logic [9:0] board_sw,
   input  logic [1:0] avs_address,
   input  logic       avs_read,
   input  logic       avs_write,
   input  logic [7:0] avs_writedata,
   output logic [7:0] avs_readdata,
   input  logic       cpu_4016_wr,
   input  logic       cpu_wdata0,
   input  logic       cpu_4016_rd,
   output logic       joy1_data
);

   // Keys are inverted up front so every debounced bit means "pressed"
   logic [8:0] raw;
   logic [8:0] db;
   logic       unused_sw;

   assign raw       = {board_sw[9], board_sw[3:0], ~board_key};
   assign unused_sw = ^board_sw[8:4];

   for (genvar i = 0; i < 9; i++) begin : g_db
      joypad_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .SYNC_STAGES     (SYNC_STAGES)
      ) u_db (
         .clk   (clk_clk),
         .rst_n (reset_reset_n),
         .din   (raw[i]),
         .dout  (db[i])
      );
   end

   logic [7:0] hps_pad_q, hps_pad_d;
   logic [1:0] ctrl_q, ctrl_d;
   logic [7:0] pad_q, pad_d;
   logic       strobe_q, strobe_d;
   logic [7:0] shift_q, shift_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] rdata_q, rdata_d;
   logic [7:0] board_w;
   mode_e      mode_eff;

   always_comb begin
      board_w             = '0;
      board_w[BTN_A]      = db[0];
      board_w[BTN_B]      = db[1];
      board_w[BTN_SELECT] = db[2];
      board_w[BTN_START]  = db[3];
      board_w[BTN_UP]     = db[4];
      board_w[BTN_DOWN]   = db[5];
      board_w[BTN_LEFT]   = db[6];
      board_w[BTN_RIGHT]  = db[7];
      mode_eff = db[8] ? MODE_BOARD : mode_e'(ctrl_q);
      pad_d    = merge_pad(mode_eff, board_w, hps_pad_q);
   end

   always_comb begin
      hps_pad_d = hps_pad_q;
      ctrl_d    = ctrl_q;
      rdata_d   = rdata_q;
      if (avs_read) begin
         case (avs_address)
            REG_HPS_PAD:   rdata_d = hps_pad_q;
            REG_CTRL:      rdata_d = {6'b0, ctrl_q};
            REG_PAD_STATE: rdata_d = pad_q;
            default:       rdata_d = {4'b0, cnt_q};
         endcase
      end
      if (avs_write) begin
         case (avs_address)
            REG_HPS_PAD: hps_pad_d = avs_writedata;
            REG_CTRL:    ctrl_d    = avs_writedata[1:0];
            default:     ;
         endcase
      end
   end

   // A read coinciding with a $4016 write never shifts
   always_comb begin
      strobe_d = cpu_4016_wr ? cpu_wdata0 : strobe_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      if (strobe_q) begin
         shift_d = pad_q;
         cnt_d   = '0;
      end else if (cpu_4016_rd && !cpu_4016_wr) begin
         shift_d = {1'b1, shift_q[7:1]};
         if (cnt_q != SHIFT_SAT) cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         hps_pad_q <= '0;
         ctrl_q    <= '0;
         pad_q     <= '0;
         strobe_q  <= 1'b0;
         shift_q   <= '0;
         cnt_q     <= '0;
         rdata_q   <= '0;
      end else begin
         hps_pad_q <= hps_pad_d;
         ctrl_q    <= ctrl_d;
         pad_q     <= pad_d;
         strobe_q  <= strobe_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         rdata_q   <= rdata_d;
      end
   end

   assign joy1_data    = shift_q[0];
   assign avs_readdata = rdata_q;

endmodule

// File: tb/tb_nes_joypad_ctrl.sv
// Directed bench for nes_joypad_ctrl with a short debounce window.
module tb_nes_joypad_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] key;
   logic [9:0] sw;
   logic [1:0] addr;
   logic       rd, wr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       c_wr, c_d0, c_rd;
   logic       joy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   nes_joypad_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .SYNC_STAGES     (2)
   ) dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .board_key     (key),
      .board_sw      (sw),
      .avs_address   (addr),
      .avs_read      (rd),
      .avs_write     (wr),
      .avs_writedata (wdata),
      .avs_readdata  (rdata),
      .cpu_4016_wr   (c_wr),
      .cpu_wdata0    (c_d0),
      .cpu_4016_rd   (c_rd),
      .joy1_data     (joy)
   );

   task automatic check(input string tag, input logic [7:0] got,
                        input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %02h exp %02h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic avs_wr(input logic [1:0] a, input logic [7:0] d);
      addr = a; wdata = d; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic avs_rd(input logic [1:0] a, output logic [7:0] d);
      addr = a; rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      d = rdata;
   endtask

   task automatic cpu_wr(input logic b);
      c_d0 = b; c_wr = 1'b1;
      @(negedge clk);
      c_wr = 1'b0;
   endtask

   task automatic cpu_rd(output logic b);
      c_rd = 1'b1;
      #1 b = joy;
      @(negedge clk);
      c_rd = 1'b0;
   endtask

   logic [7:0] v;
   logic       b;
   logic [9:0] exp_bits;
   int         tries;

   initial begin
      rst_n = 1'b0; key = 4'hF; sw = '0;
      addr = '0; rd = 0; wr = 0; wdata = '0;
      c_wr = 0; c_d0 = 0; c_rd = 0;
      tick(3);
      rst_n = 1'b1;
      check("rst_rdata", rdata, 8'h00);
      check("rst_joy", {7'b0, joy}, 8'h00);
      for (int i = 0; i < 4; i++) begin
         avs_rd(2'(i), v);
         check($sformatf("rst_reg%0d", i), v, 8'h00);
      end

      // short glitch on key[0] must be filtered
      key[0] = 1'b0; tick(3); key[0] = 1'b1; tick(10);
      avs_rd(2'd2, v);
      check("glitch_pad", v, 8'h00);

      key[0] = 1'b0;
      tries = 0;
      v = 8'h00;
      while (v != 8'h01 && tries < 10) begin
         avs_rd(2'd2, v);
         tries++;
      end
      check("press_pad", v, 8'h01);

      // strobe held high: every read returns A, no counting
      cpu_wr(1'b1); tick(1);
      for (int i = 0; i < 5; i++) begin
         cpu_rd(b);
         check($sformatf("strobe_rd%0d", i), {7'b0, b}, 8'h01);
      end
      avs_rd(2'd3, v);
      check("strobe_cnt", v, 8'h00);
      cpu_wr(1'b0);
      key = 4'hF; tick(10);

      // HPS-only serial read of 0xA5
      avs_wr(2'd0, 8'hA5);
      avs_wr(2'd1, 8'h01);
      tick(2);
      cpu_wr(1'b1); tick(1); cpu_wr(1'b0);
      exp_bits = 10'b11_1010_0101;
      for (int i = 0; i < 10; i++) begin
         cpu_rd(b);
         check($sformatf("ser_rd%0d", i), {7'b0, b}, {7'b0, exp_bits[i]});
      end
      avs_rd(2'd3, v);
      check("ser_cnt", v, 8'h08);

      // coincident $4016 write and read after three shifts
      cpu_wr(1'b1); tick(1); cpu_wr(1'b0);
      for (int i = 0; i < 3; i++) cpu_rd(b);
      c_wr = 1'b1; c_d0 = 1'b1; c_rd = 1'b1;
      #1 check("coinc_joy", {7'b0, joy}, 8'h00);
      @(negedge clk);
      c_wr = 1'b0; c_rd = 1'b0;
      tick(1);
      check("reload_joy", {7'b0, joy}, 8'h01);
      cpu_wr(1'b0);

      // OR-merge, then sw9 forces board only
      avs_wr(2'd1, 8'hFE);
      avs_wr(2'd0, 8'h10);
      key[1] = 1'b0; tick(12);
      avs_rd(2'd2, v);
      check("merge_pad", v, 8'h12);
      sw[9] = 1'b1; tick(12);
      avs_rd(2'd2, v);
      check("force_pad", v, 8'h02);
      avs_rd(2'd1, v);
      check("force_ctrl", v, 8'h02);
      avs_wr(2'd2, 8'hFF);
      avs_rd(2'd2, v);
      check("ro_pad", v, 8'h02);
      sw[9] = 1'b0; key = 4'hF; tick(12);

      // simultaneous read and write returns the old value
      addr = 2'd0; wdata = 8'h33; rd = 1'b1; wr = 1'b1;
      @(negedge clk);
      rd = 1'b0; wr = 1'b0;
      check("rw_old", rdata, 8'h10);
      avs_rd(2'd0, v);
      check("rw_new", v, 8'h33);

      // reset in the middle of a read sequence
      avs_wr(2'd1, 8'h01);
      avs_wr(2'd0, 8'hA5);
      tick(2);
      cpu_wr(1'b1); tick(1); cpu_wr(1'b0);
      for (int i = 0; i < 4; i++) cpu_rd(b);
      rst_n = 1'b0; tick(2); rst_n = 1'b1;
      check("mid_joy", {7'b0, joy}, 8'h00);
      for (int i = 0; i < 4; i++) begin
         avs_rd(2'(i), v);
         check($sformatf("mid_reg%0d", i), v, 8'h00);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
